// File: rtl/vga_status_display.sv
// vga_status_display: pixel source for the 1024x768 passage status panel.
// Renders a full-width status banner and a 4-digit seven-segment passage
// counter as registered RGB565, answering the timing stage's pixel requests.
// The image only changes at frame boundaries, so frames never tear.
// Build option: define VGA_DENY_BLINK_EN to make the DENY banner blink;
// without it the DENY banner is steady red and no blink logic is built.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | no status held, ready for the next access event (blue banner)
// S_GRANT | granted passage shown for HOLD_FRAMES frames (green banner)
// S_DENY  | denied passage shown for HOLD_FRAMES frames (red banner)
module vga_status_display #(
  parameter int H_DISP       = 1024,
  parameter int V_DISP       = 768,
  parameter int HOLD_FRAMES  = 120,
  parameter int BLINK_FRAMES = 30,
  parameter int DIG_X0       = 384,
  parameter int DIG_Y0       = 320
) (
  input  logic        vga_clk,
  input  logic        sys_rst,
  input  logic        data_req,
  input  logic [10:0] pixel_xpos,
  input  logic [10:0] pixel_ypos,
  input  logic        evt_valid,
  input  logic        evt_pass,
  output logic        evt_ready,
  output logic [15:0] pixel_data,
  output logic [15:0] pass_cnt
);

  localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_DENY  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  state_t            r_disp_state;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [15:0]       r_pass_cnt;
  logic [15:0]       r_disp_digits;
  logic [15:0]       r_pixel;
  logic              w_frame_end;
  logic              w_accept;
  logic [15:0]       w_deny_colour;
  logic [15:0]       w_colour;
  logic [11:0]       w_x;
  logic [11:0]       w_y;
  logic [11:0]       w_u;
  logic [11:0]       w_v;
  logic [3:0]        w_digit;
  logic [6:0]        w_segs;
  logic              w_seg_on;

  // BCD +1 that sticks at 9999
  function automatic logic [15:0] bcd_inc(input logic [15:0] val);
    logic [15:0] res;
    logic        carry;
    res   = val;
    carry = 1'b1;
    if (val == 16'h9999) return val;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (res[4*i +: 4] == 4'd9) begin
          res[4*i +: 4] = 4'd0;
        end else begin
          res[4*i +: 4] = res[4*i +: 4] + 4'd1;
          carry         = 1'b0;
        end
      end
    end
    return res;
  endfunction

  // Segment pattern {a,b,c,d,e,f,g}; non-decimal codes stay dark
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1111110;
      4'd1:    return 7'b0110000;
      4'd2:    return 7'b1101101;
      4'd3:    return 7'b1111001;
      4'd4:    return 7'b0110011;
      4'd5:    return 7'b1011011;
      4'd6:    return 7'b1011111;
      4'd7:    return 7'b1110000;
      4'd8:    return 7'b1111111;
      4'd9:    return 7'b1111011;
      default: return 7'b0000000;
    endcase
  endfunction

  // Is cell-local (u,v) inside any lit segment rectangle
  function automatic logic seg_hit(input logic [11:0] u, input logic [11:0] v,
                                   input logic [6:0] s);
    logic mid, lft, rgt, top, bot;
    mid = (u >= 12'd8)  && (u <= 12'd55);
    lft = (u <= 12'd15);
    rgt = (u >= 12'd48) && (u <= 12'd63);
    top = (v >= 12'd8)  && (v <= 12'd63);
    bot = (v >= 12'd64) && (v <= 12'd119);
    return (s[6] && mid && (v <= 12'd15))
        || (s[5] && rgt && top)
        || (s[4] && rgt && bot)
        || (s[3] && mid && (v >= 12'd112) && (v <= 12'd127))
        || (s[2] && lft && bot)
        || (s[1] && lft && top)
        || (s[0] && mid && (v >= 12'd56) && (v <= 12'd71));
  endfunction

  assign w_frame_end = data_req && (pixel_xpos == 11'(H_DISP))
                                && (pixel_ypos == 11'(V_DISP));

  // Control state register
  always_ff @(posedge vga_clk) begin
    if (sys_rst) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next state and event handshake
  always_comb begin
    w_state_nxt = r_state;
    evt_ready   = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        evt_ready = 1'b1;
        w_accept  = evt_valid;
        if (evt_valid) w_state_nxt = evt_pass ? S_GRANT : S_DENY;
      end
      S_GRANT, S_DENY: begin
        if (w_frame_end && (r_hold_cnt == HOLD_W'(1))) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Hold timer and passage counter; a frame_end in the accept cycle does not
  // count against the fresh hold, because the state was still IDLE then
  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      r_hold_cnt <= '0;
      r_pass_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_hold_cnt <= HOLD_W'(HOLD_FRAMES);
      end else if ((r_state != S_IDLE) && w_frame_end && (r_hold_cnt != '0)) begin
        r_hold_cnt <= r_hold_cnt - HOLD_W'(1);
      end
      if (w_accept && evt_pass) r_pass_cnt <= bcd_inc(r_pass_cnt);
    end
  end

  // Frame-boundary snapshot of what the next frame shows
  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      r_disp_state  <= S_IDLE;
      r_disp_digits <= '0;
    end else if (w_frame_end) begin
      r_disp_state  <= r_state;
      r_disp_digits <= r_pass_cnt;
    end
  end

`ifdef VGA_DENY_BLINK_EN
  localparam int BLK_W = $clog2(BLINK_FRAMES + 1);

  logic [BLK_W-1:0] r_blink_cnt;
  logic             r_blink_ph;
  logic             r_blink_on;

  // Live blink phase advances per DENY frame; the shown copy follows at frame_end
  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      r_blink_cnt <= '0;
      r_blink_ph  <= 1'b1;
      r_blink_on  <= 1'b1;
    end else begin
      if (w_accept && !evt_pass) begin
        r_blink_cnt <= '0;
        r_blink_ph  <= 1'b1;
      end else if (w_frame_end && (r_state == S_DENY)) begin
        if (r_blink_cnt == BLK_W'(BLINK_FRAMES - 1)) begin
          r_blink_cnt <= '0;
          r_blink_ph  <= ~r_blink_ph;
        end else begin
          r_blink_cnt <= r_blink_cnt + BLK_W'(1);
        end
      end
      if (w_frame_end) r_blink_on <= r_blink_ph;
    end
  end

  assign w_deny_colour = r_blink_on ? 16'hF800 : 16'h0000;
`else
  assign w_deny_colour = 16'hF800;
`endif

  assign w_x = {1'b0, pixel_xpos} - 12'd1;
  assign w_y = {1'b0, pixel_ypos} - 12'd1;

  // Locate the digit cell under the pixel and test its segments
  always_comb begin
    w_u      = '0;
    w_v      = '0;
    w_digit  = '0;
    w_segs   = '0;
    w_seg_on = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if ((w_x >= 12'(DIG_X0 + 80*k)) && (w_x <= 12'(DIG_X0 + 80*k + 63)) &&
          (w_y >= 12'(DIG_Y0))        && (w_y <= 12'(DIG_Y0 + 127))) begin
        w_u      = w_x - 12'(DIG_X0 + 80*k);
        w_v      = w_y - 12'(DIG_Y0);
        w_digit  = r_disp_digits[15-4*k -: 4];
        w_segs   = seg_decode(w_digit);
        w_seg_on = seg_hit(w_u, w_v, w_segs);
      end
    end
  end

  // Pixel colour: banner first, then digit segments, else black
  always_comb begin
    w_colour = 16'h0000;
    if (w_y < 12'd128) begin
      case (r_disp_state)
        S_GRANT: w_colour = 16'h07E0;
        S_DENY:  w_colour = w_deny_colour;
        default: w_colour = 16'h001F;
      endcase
    end else if (w_seg_on) begin
      w_colour = 16'hFFFF;
    end
  end

  // One-cycle registered pixel output
  always_ff @(posedge vga_clk) begin
    if (sys_rst) r_pixel <= '0;
    else         r_pixel <= data_req ? w_colour : 16'h0000;
  end

  assign pixel_data = r_pixel;
  assign pass_cnt   = r_pass_cnt;

endmodule
